// File: rtl/sram_controller_if.sv
// Avalon-MM bundle between the upstream bus adapter and the SRAM controller.
// Master side drives address/read/write/byteenable/writedata; slave side
// returns readdata/readdatavalid and the combinational waitrequest stall.
interface sram_controller_if #(
  parameter int unsigned AVL_AW = 26
);
  logic [AVL_AW-1:0] address;
  logic              read;
  logic              write;
  logic [1:0]        byteenable;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sram_controller.sv
// Avalon-MM slave driving an asynchronous 256Kx16 SRAM.
// Reads: one per cycle, fixed 2-cycle latency. Writes: WE_N pulse cycle then
// a recovery cycle, so at most one write every two cycles.
//
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   avl               - Avalon-MM slave bundle (sram_controller_if.slave)
//   sram_addr         - SRAM word address (byte address bits [SRAM_AW:1])
//   sram_dq_i/_o/_oe  - split bidirectional data pad, oe=1 drives the pad
//   sram_*_n          - active-low SRAM strobes, all registered
module sram_controller #(
  parameter int unsigned AVL_AW  = 26,
  parameter int unsigned SRAM_AW = 18
) (
  input  logic               clock,
  input  logic               reset,
  sram_controller_if.slave   avl,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  typedef enum logic [1:0] {StIdle, StWrite, StWrRecover} state_e;

  state_e               state_q;
  logic [SRAM_AW-1:0]   addr_q;
  logic [15:0]          dq_o_q;
  logic                 dq_oe_q;
  logic                 ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic                 rd_stage1_q;
  logic                 rdv_q;
  logic [15:0]          readdata_q;

  logic                 waitrequest;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [SRAM_AW-1:0]   word_addr;

  // Byte-address bit 0 and bits above the SRAM range are dropped (addresses wrap).
  assign word_addr = avl.address[SRAM_AW:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{avl.address[AVL_AW-1:SRAM_AW+1], avl.address[0]};

  always_comb begin
    waitrequest = 1'b0;
    unique case (state_q)
      StIdle:      waitrequest = 1'b0;
      StWrite:     waitrequest = 1'b1;
      // A write may chain straight in; a read waits one cycle for the bus to turn.
      StWrRecover: waitrequest = avl.read;
      default:     waitrequest = 1'b0;
    endcase
  end

  // Write wins when read and write are both high; the read is silently dropped.
  assign wr_acc = avl.write & ~waitrequest;
  assign rd_acc = avl.read & ~avl.write & ~waitrequest;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      rd_stage1_q <= 1'b0;
      rdv_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      // Stage 2 samples the pad while stage-1 read pins are still on the SRAM.
      rdv_q       <= rd_stage1_q;
      if (rd_stage1_q) begin
        readdata_q <= sram_dq_i;
      end
      rd_stage1_q <= 1'b0;

      if (wr_acc) begin
        state_q <= StWrite;
        addr_q  <= word_addr;
        dq_o_q  <= avl.writedata;
        dq_oe_q <= 1'b1;
        ce_n_q  <= 1'b0;
        oe_n_q  <= 1'b1;
        // byteenable=00 keeps WE_N high but still spends the full write slot.
        we_n_q  <= ~|avl.byteenable;
        ub_n_q  <= ~avl.byteenable[1];
        lb_n_q  <= ~avl.byteenable[0];
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rd_acc) begin
              addr_q      <= word_addr;
              dq_oe_q     <= 1'b0;
              ce_n_q      <= 1'b0;
              oe_n_q      <= 1'b0;
              we_n_q      <= 1'b1;
              ub_n_q      <= 1'b0;
              lb_n_q      <= 1'b0;
              rd_stage1_q <= 1'b1;
            end else begin
              dq_oe_q <= 1'b0;
              ce_n_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              we_n_q  <= 1'b1;
              ub_n_q  <= 1'b1;
              lb_n_q  <= 1'b1;
            end
          end
          StWrite: begin
            // Recovery: WE_N rises while address and data stay on the pins.
            state_q <= StWrRecover;
            we_n_q  <= 1'b1;
          end
          StWrRecover: begin
            state_q <= StIdle;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign avl.waitrequest   = waitrequest;
  assign avl.readdata      = readdata_q;
  assign avl.readdatavalid = rdv_q;

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule
